// File: rtl/axil_slv_regs.sv
// AXI4-Lite slave register file: two RW control registers (mode, count_max) and
// two RO status words from the count/measure engine, one outstanding op per direction.
module axil_slv_regs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   o_slv_reg0,
    output logic [DATA_W-1:0]   o_slv_reg1,
    output logic                o_reg0_wr,
    input  logic [DATA_W-1:0]   i_slv_reg2,
    input  logic [DATA_W-1:0]   i_slv_reg3
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    function automatic logic [DATA_W-1:0] apply_strb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // write channel state
    w_state_t            w_state_r, w_state_s;
    logic                aw_held_r, aw_held_s;
    logic                w_held_r, w_held_s;
    logic                awready_r, awready_s;
    logic                wready_r, wready_s;
    logic [1:0]          aw_idx_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                reg0_wr_r;
    logic [DATA_W-1:0]   slv_reg0_r, slv_reg1_r;
    logic                aw_hs_s, w_hs_s, commit_s, b_done_s;

    // read channel state
    r_state_t            r_state_r, r_state_s;
    logic                ar_held_r, ar_held_s;
    logic                arready_r, arready_s;
    logic [1:0]          ar_idx_r;
    logic                rvalid_r;
    logic [DATA_W-1:0]   rdata_r, rd_mux_s;
    logic [1:0]          rresp_r;
    logic                ar_hs_s, load_s, r_done_s;

    logic                unused_s;
    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    // Write next-state: AW and W are latched independently; commit once both are held.
    always_comb begin
        aw_hs_s   = s_axi_awvalid && awready_r;
        w_hs_s    = s_axi_wvalid && wready_r;
        commit_s  = aw_held_r && w_held_r;
        b_done_s  = bvalid_r && s_axi_bready;
        w_state_s = w_state_r;
        if (commit_s) begin
            aw_held_s = 1'b0;
            w_held_s  = 1'b0;
        end else begin
            aw_held_s = aw_held_r || aw_hs_s;
            w_held_s  = w_held_r || w_hs_s;
        end
        case (w_state_r)
            W_IDLE, W_HAVE_AW, W_HAVE_W: begin
                if (commit_s) begin
                    w_state_s = W_RESP;
                end else if (aw_held_s && !w_held_s) begin
                    w_state_s = W_HAVE_AW;
                end else if (!aw_held_s && w_held_s) begin
                    w_state_s = W_HAVE_W;
                end else if (aw_held_s && w_held_s) begin
                    // both held for one cycle before commit; keep whichever arrived first
                    w_state_s = (w_state_r == W_HAVE_W) ? W_HAVE_W : W_HAVE_AW;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (b_done_s) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
        awready_s = !aw_held_s && (w_state_s != W_RESP);
        wready_s  = !w_held_s && (w_state_s != W_RESP);
    end

    // Write registers: holding regs, register commit, and B channel.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            w_state_r  <= W_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            aw_idx_r   <= 2'd0;
            wdata_r    <= {DATA_W{1'b0}};
            wstrb_r    <= {STRB_W{1'b0}};
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            reg0_wr_r  <= 1'b0;
            slv_reg0_r <= {DATA_W{1'b0}};
            slv_reg1_r <= {DATA_W{1'b0}};
        end else begin
            w_state_r <= w_state_s;
            aw_held_r <= aw_held_s;
            w_held_r  <= w_held_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            reg0_wr_r <= 1'b0;
            if (aw_hs_s) begin
                aw_idx_r <= s_axi_awaddr[3:2];
            end
            if (w_hs_s) begin
                wdata_r <= s_axi_wdata;
                wstrb_r <= s_axi_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                case (aw_idx_r)
                    2'd0: begin
                        slv_reg0_r <= apply_strb(slv_reg0_r, wdata_r, wstrb_r);
                        reg0_wr_r  <= |wstrb_r;
                        bresp_r    <= RESP_OKAY;
                    end
                    2'd1: begin
                        slv_reg1_r <= apply_strb(slv_reg1_r, wdata_r, wstrb_r);
                        bresp_r    <= RESP_OKAY;
                    end
                    default: begin
                        bresp_r <= RESP_SLVERR;
                    end
                endcase
            end else if (b_done_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read next-state and data select; status inputs are sampled only at load.
    always_comb begin
        ar_hs_s   = s_axi_arvalid && arready_r;
        load_s    = ar_held_r;
        r_done_s  = rvalid_r && s_axi_rready;
        ar_held_s = load_s ? 1'b0 : (ar_held_r || ar_hs_s);
        case (r_state_r)
            R_IDLE:  r_state_s = load_s ? R_RESP : R_IDLE;
            R_RESP:  r_state_s = r_done_s ? R_IDLE : R_RESP;
            default: r_state_s = R_IDLE;
        endcase
        arready_s = !ar_held_s && (r_state_s == R_IDLE);
        case (ar_idx_r)
            2'd0:    rd_mux_s = slv_reg0_r;
            2'd1:    rd_mux_s = slv_reg1_r;
            2'd2:    rd_mux_s = i_slv_reg2;
            2'd3:    rd_mux_s = i_slv_reg3;
            default: rd_mux_s = {DATA_W{1'b0}};
        endcase
    end

    // Read registers: AR holding, R channel.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state_r <= R_IDLE;
            ar_held_r <= 1'b0;
            arready_r <= 1'b0;
            ar_idx_r  <= 2'd0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            ar_held_r <= ar_held_s;
            arready_r <= arready_s;
            if (ar_hs_s) begin
                ar_idx_r <= s_axi_araddr[3:2];
            end
            if (load_s) begin
                rdata_r  <= rd_mux_s;
                rresp_r  <= RESP_OKAY;
                rvalid_r <= 1'b1;
            end else if (r_done_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign o_slv_reg0    = slv_reg0_r;
    assign o_slv_reg1    = slv_reg1_r;
    assign o_reg0_wr     = reg0_wr_r;

endmodule

// File: tb/tb_axil_slv_regs.sv
// Bench for axil_slv_regs: directed scenarios plus randomized traffic checked
// against a register-map model (byte-lane merge, response and pulse rules).
`timescale 1ns/1ps
module tb_axil_slv_regs;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [3:0]  s_axi_awaddr = 4'h0;
    logic [2:0]  s_axi_awprot = 3'b000;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = 32'h0;
    logic [3:0]  s_axi_wstrb = 4'h0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = 4'h0;
    logic [2:0]  s_axi_arprot = 3'b000;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] o_slv_reg0, o_slv_reg1;
    logic        o_reg0_wr;
    logic [31:0] i_slv_reg2 = 32'h0;
    logic [31:0] i_slv_reg3 = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_reg0 = 32'h0;
    logic [31:0] model_reg1 = 32'h0;

    axil_slv_regs #(.DATA_W(32), .ADDR_W(4)) dut (
        .iclk(iclk), .irst(irst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .o_slv_reg0(o_slv_reg0), .o_slv_reg1(o_slv_reg1), .o_reg0_wr(o_reg0_wr),
        .i_slv_reg2(i_slv_reg2), .i_slv_reg3(i_slv_reg3)
    );

    always #5 iclk = ~iclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

    // Drives one write; AW/W appear after their own delays, bready after b_dly cycles of bvalid.
    // lat = edges from last of AW/W handshake to bvalid; bad flags protocol violations.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int lat, output int pulses,
                             output bit bad, output bit tmo);
        bit aw_done, w_done, aw_f, w_f, b_fire;
        int hs_edge, b_seen;
        aw_done = 1'b0; w_done = 1'b0; hs_edge = -1; b_seen = -1;
        resp = 2'b11; lat = -1; pulses = 0; bad = 1'b0; tmo = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            s_axi_awaddr  = addr;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            s_axi_bready  = (b_seen >= 0) && (cyc - b_seen > b_dly);
            @(negedge iclk);
            if (aw_done && s_axi_awready) bad = 1'b1;
            if (w_done && s_axi_wready) bad = 1'b1;
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            b_fire = s_axi_bvalid && s_axi_bready;
            if (aw_f) aw_done = 1'b1;
            if (w_f) w_done = 1'b1;
            if ((aw_f || w_f) && aw_done && w_done) hs_edge = cyc;
            @(posedge iclk);
            #1;
            if (o_reg0_wr) pulses++;
            if (b_fire) begin
                tmo = 1'b0;
                if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) bad = 1'b1;
                break;
            end
            if (s_axi_bvalid) begin
                if (b_seen < 0) begin
                    b_seen = cyc;
                    lat = cyc - hs_edge;
                    resp = s_axi_bresp;
                end else if (s_axi_bresp !== resp) begin
                    bad = 1'b1;
                end
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        @(posedge iclk);
        #1;
        if (o_reg0_wr) pulses++;
    endtask

    // Drives one read; rready rises r_dly cycles after rvalid. lat = edges from AR handshake to rvalid.
    task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data,
                            output int lat, output bit bad, output bit tmo);
        bit fire;
        int hs, seen;
        hs = -1; seen = -1; data = 32'h0; lat = -1; bad = 1'b0; tmo = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            s_axi_araddr  = addr;
            s_axi_arvalid = (hs < 0);
            s_axi_rready  = (seen >= 0) && (cyc - seen > r_dly);
            @(negedge iclk);
            if (hs >= 0 && s_axi_arready) bad = 1'b1;
            fire = s_axi_rvalid && s_axi_rready;
            if (s_axi_arvalid && s_axi_arready) hs = cyc;
            @(posedge iclk);
            #1;
            if (fire) begin
                tmo = 1'b0;
                if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) bad = 1'b1;
                break;
            end
            if (s_axi_rvalid) begin
                if (seen < 0) begin
                    seen = cyc;
                    lat = cyc - hs;
                    data = s_axi_rdata;
                    if (s_axi_rresp !== 2'b00) bad = 1'b1;
                end else if (s_axi_rdata !== data || s_axi_rresp !== 2'b00) begin
                    bad = 1'b1;
                end
            end
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, o_reg0_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl actual=%b expected=000000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, o_reg0_wr});
        end
        checks++;
        if ({o_slv_reg0, o_slv_reg1, s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data reg0=%h reg1=%h rdata=%h bresp=%b rresp=%b expected all zero",
                     o_slv_reg0, o_slv_reg1, s_axi_rdata, s_axi_bresp, s_axi_rresp);
        end
        @(posedge iclk);
        #2 irst = 1'b0;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_early actual=%b expected=000", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        @(posedge iclk);
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_rise actual=%b expected=111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [1:0] resp; int lat, pulses; bit bad, tmo;
        axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0, 0, resp, lat, pulses, bad, tmo);
        model_reg0 = 32'h0000_0001;
        checks++;
        if (tmo !== 1'b0 || bad !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL same_cycle_proto tmo=%0d bad=%0d lat=%0d expected 0 0 1", tmo, bad, lat);
        end
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL same_cycle_bresp actual=%b expected=00", resp); end
        checks++;
        if (o_slv_reg0 !== model_reg0) begin errors++; $display("FAIL same_cycle_reg0 actual=%h expected=%h", o_slv_reg0, model_reg0); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL same_cycle_pulse actual=%0d expected=1", pulses); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat, pulses; bit bad, tmo;
        axi_write(4'h4, 32'h0000_03E8, 4'hF, 3, 0, 1, resp, lat, pulses, bad, tmo);
        model_reg1 = 32'd1000;
        checks++;
        if (tmo !== 1'b0 || bad !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL w_first_proto tmo=%0d bad=%0d lat=%0d expected 0 0 1", tmo, bad, lat);
        end
        checks++;
        if (o_slv_reg1 !== model_reg1 || resp !== 2'b00 || pulses !== 0) begin
            errors++;
            $display("FAIL w_first_result reg1=%h resp=%b pulses=%0d expected %h 00 0", o_slv_reg1, resp, pulses, model_reg1);
        end
    endtask

    task automatic test_read_hold();
        logic [31:0] data; int lat; bit bad, tmo;
        i_slv_reg2 = 32'h1234_5678;
        axi_read(4'h8, 5, data, lat, bad, tmo);
        checks++;
        if (tmo !== 1'b0 || bad !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL read_hold_proto tmo=%0d bad=%0d lat=%0d expected 0 0 1", tmo, bad, lat);
        end
        checks++;
        if (data !== 32'h1234_5678) begin errors++; $display("FAIL read_hold_data actual=%h expected=12345678", data); end
    endtask

    task automatic test_ro_write();
        logic [1:0] resp; int lat, pulses; bit bad, tmo;
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 1, 0, 2, resp, lat, pulses, bad, tmo);
        checks++;
        if (tmo !== 1'b0 || bad !== 1'b0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL ro_write_resp tmo=%0d bad=%0d resp=%b expected 0 0 10", tmo, bad, resp);
        end
        checks++;
        if (o_slv_reg0 !== model_reg0 || o_slv_reg1 !== model_reg1 || pulses !== 0) begin
            errors++;
            $display("FAIL ro_write_regs reg0=%h reg1=%h pulses=%0d expected %h %h 0",
                     o_slv_reg0, o_slv_reg1, pulses, model_reg0, model_reg1);
        end
    endtask

    task automatic test_partial();
        logic [1:0] resp; int lat, pulses; bit bad, tmo;
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, resp, lat, pulses, bad, tmo);
        axi_write(4'h4, 32'hAABB_CCDD, 4'h3, 0, 1, 0, resp, lat, pulses, bad, tmo);
        model_reg1 = 32'h0000_CCDD;
        checks++;
        if (o_slv_reg1 !== model_reg1 || resp !== 2'b00 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL partial_reg1 actual=%h resp=%b expected=%h 00", o_slv_reg1, resp, model_reg1);
        end
        axi_write(4'h0, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, resp, lat, pulses, bad, tmo);
        checks++;
        if (o_slv_reg0 !== model_reg0 || resp !== 2'b00 || pulses !== 0 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL zero_strb reg0=%h resp=%b pulses=%0d expected %h 00 0", o_slv_reg0, resp, pulses, model_reg0);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; int lat, pulses; bit bad, tmo;
        s_axi_awaddr = 4'h0; s_axi_wdata = 32'h0000_0005; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge iclk);
        #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b1 || o_slv_reg0 !== 32'h5) begin
            errors++;
            $display("FAIL rst_mid_pending bvalid=%b reg0=%h expected 1 00000005", s_axi_bvalid, o_slv_reg0);
        end
        #2 irst = 1'b1;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || o_slv_reg0 !== 32'h0 || o_slv_reg1 !== 32'h0 || s_axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async bvalid=%b reg0=%h reg1=%h awready=%b expected 0 0 0 0",
                     s_axi_bvalid, o_slv_reg0, o_slv_reg1, s_axi_awready);
        end
        model_reg0 = 32'h0;
        model_reg1 = 32'h0;
        @(posedge iclk);
        #2 irst = 1'b0;
        @(posedge iclk);
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || {s_axi_awready, s_axi_wready} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_release bvalid=%b readys=%b expected 0 11", s_axi_bvalid, {s_axi_awready, s_axi_wready});
        end
        axi_write(4'h4, 32'h1357_9BDF, 4'hF, 0, 0, 0, resp, lat, pulses, bad, tmo);
        model_reg1 = 32'h1357_9BDF;
        checks++;
        if (tmo !== 1'b0 || bad !== 1'b0 || resp !== 2'b00 || o_slv_reg1 !== model_reg1) begin
            errors++;
            $display("FAIL rst_mid_fresh tmo=%0d bad=%0d resp=%b reg1=%h expected 0 0 00 %h",
                     tmo, bad, resp, o_slv_reg1, model_reg1);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp; int wlat, pulses, rlat; bit wbad, wtmo, rbad, rtmo; logic [31:0] data;
        logic [31:0] exp_rd;
        exp_rd = model_reg0;
        fork
            axi_write(4'h5, 32'h0BAD_F00D, 4'hC, 1, 2, 1, resp, wlat, pulses, wbad, wtmo);
            axi_read(4'h2, 2, data, rlat, rbad, rtmo);
        join
        model_reg1 = merge(model_reg1, 32'h0BAD_F00D, 4'hC);
        checks++;
        if (wtmo !== 1'b0 || wbad !== 1'b0 || resp !== 2'b00 || o_slv_reg1 !== model_reg1) begin
            errors++;
            $display("FAIL concurrent_write tmo=%0d bad=%0d resp=%b reg1=%h expected 0 0 00 %h",
                     wtmo, wbad, resp, o_slv_reg1, model_reg1);
        end
        checks++;
        if (rtmo !== 1'b0 || rbad !== 1'b0 || rlat !== 1 || data !== exp_rd) begin
            errors++;
            $display("FAIL concurrent_read tmo=%0d bad=%0d lat=%0d data=%h expected 0 0 1 %h",
                     rtmo, rbad, rlat, data, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, exp_resp; int lat, pulses, exp_pulses; bit bad, tmo;
        logic [31:0] data, wd, exp_rd; logic [3:0] addr, strb; logic [1:0] idx;
        for (int n = 0; n < 40; n++) begin
            idx  = 2'($urandom_range(0, 3));
            addr = {idx, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 0) begin
                wd   = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          resp, lat, pulses, bad, tmo);
                exp_resp = (idx >= 2'd2) ? 2'b10 : 2'b00;
                exp_pulses = (idx == 2'd0 && strb != 4'h0) ? 1 : 0;
                if (idx == 2'd0) model_reg0 = merge(model_reg0, wd, strb);
                if (idx == 2'd1) model_reg1 = merge(model_reg1, wd, strb);
                checks++;
                if (tmo !== 1'b0 || bad !== 1'b0 || lat !== 1 || resp !== exp_resp || pulses !== exp_pulses) begin
                    errors++;
                    $display("FAIL rand_write[%0d] addr=%h tmo=%0d bad=%0d lat=%0d resp=%b pulses=%0d expected 0 0 1 %b %0d",
                             n, addr, tmo, bad, lat, resp, pulses, exp_resp, exp_pulses);
                end
                checks++;
                if (o_slv_reg0 !== model_reg0 || o_slv_reg1 !== model_reg1) begin
                    errors++;
                    $display("FAIL rand_regs[%0d] reg0=%h reg1=%h expected %h %h",
                             n, o_slv_reg0, o_slv_reg1, model_reg0, model_reg1);
                end
            end else begin
                i_slv_reg2 = $urandom;
                i_slv_reg3 = $urandom;
                case (idx)
                    2'd0:    exp_rd = model_reg0;
                    2'd1:    exp_rd = model_reg1;
                    2'd2:    exp_rd = i_slv_reg2;
                    default: exp_rd = i_slv_reg3;
                endcase
                axi_read(addr, $urandom_range(0, 3), data, lat, bad, tmo);
                checks++;
                if (tmo !== 1'b0 || bad !== 1'b0 || lat !== 1 || data !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr=%h tmo=%0d bad=%0d lat=%0d data=%h expected 0 0 1 %h",
                             n, addr, tmo, bad, lat, data, exp_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_hold();
        test_ro_write();
        test_partial();
        test_reset_mid();
        test_concurrent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
